// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard descriptor bus and the bypass/stall controls returned to the datapath.
interface hazard_ctrl_if;
  logic [1:0] D_Tuse1;
  logic [1:0] D_Tuse2;
  logic [1:0] D_Tnew;
  logic [4:0] D_ReadA1;
  logic [4:0] D_ReadA2;
  logic [4:0] D_WriteAddr;
  logic       Stall;
  logic [1:0] Trans_grf_Sel1;
  logic [1:0] Trans_grf_Sel2;
  logic [1:0] E_Sel1;
  logic [1:0] E_Sel2;
  logic       M_Sel2;

  modport master (
    output D_Tuse1, D_Tuse2, D_Tnew, D_ReadA1, D_ReadA2, D_WriteAddr,
    input  Stall, Trans_grf_Sel1, Trans_grf_Sel2, E_Sel1, E_Sel2, M_Sel2
  );

  modport slave (
    input  D_Tuse1, D_Tuse2, D_Tnew, D_ReadA1, D_ReadA2, D_WriteAddr,
    output Stall, Trans_grf_Sel1, Trans_grf_Sel2, E_Sel1, E_Sel2, M_Sel2
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: shadow E/M/W destination pipeline driving
// decode stall, D/E/M bypass selects and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     hz,
  output logic [CNT_W-1:0] StallCount
);

  logic [4:0]       e_a1_q, e_a2_q, e_wa_q;
  logic [1:0]       e_tnew_q;
  logic [4:0]       m_a2_q, m_wa_q;
  logic [1:0]       m_tnew_q;
  logic [4:0]       w_wa_q;
  logic [CNT_W-1:0] cnt_q;

  logic [4:0]       e_a1_d, e_a2_d, e_wa_d;
  logic [1:0]       e_tnew_d;
  logic [1:0]       m_tnew_d;
  logic [CNT_W-1:0] cnt_d;
  logic             stall;

  function automatic logic op_stall(input logic [1:0] tuse, input logic [4:0] a,
                                    input logic [4:0] ewa, input logic [1:0] etn,
                                    input logic [4:0] mwa, input logic [1:0] mtn);
    return (tuse != 2'd3) && (a != 5'd0) &&
           (((ewa == a) && (etn > tuse)) || ((mwa == a) && (mtn > tuse)));
  endfunction

  // Newest producer wins: an E match hides any M match even if E cannot forward yet.
  function automatic logic [1:0] d_sel(input logic [4:0] a,
                                       input logic [4:0] ewa, input logic [1:0] etn,
                                       input logic [4:0] mwa, input logic [1:0] mtn);
    logic [1:0] sel;
    sel = 2'd0;
    if (a != 5'd0) begin
      if (ewa == a)      sel = (etn == 2'd0) ? 2'd1 : 2'd0;
      else if (mwa == a) sel = (mtn == 2'd0) ? 2'd2 : 2'd0;
    end
    return sel;
  endfunction

  function automatic logic [1:0] e_sel(input logic [4:0] a,
                                       input logic [4:0] mwa, input logic [1:0] mtn,
                                       input logic [4:0] wwa);
    logic [1:0] sel;
    sel = 2'd0;
    if (a != 5'd0) begin
      if ((mwa == a) && (mtn == 2'd0)) sel = 2'd1;
      else if (wwa == a)               sel = 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    stall = op_stall(hz.D_Tuse1, hz.D_ReadA1, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q) |
            op_stall(hz.D_Tuse2, hz.D_ReadA2, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);

    hz.Stall          = stall;
    hz.Trans_grf_Sel1 = d_sel(hz.D_ReadA1, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
    hz.Trans_grf_Sel2 = d_sel(hz.D_ReadA2, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
    hz.E_Sel1         = e_sel(e_a1_q, m_wa_q, m_tnew_q, w_wa_q);
    hz.E_Sel2         = e_sel(e_a2_q, m_wa_q, m_tnew_q, w_wa_q);
    hz.M_Sel2         = (m_a2_q != 5'd0) && (w_wa_q == m_a2_q);

    e_a1_d   = '0;
    e_a2_d   = '0;
    e_wa_d   = '0;
    e_tnew_d = '0;
    if (!stall) begin
      e_a1_d   = hz.D_ReadA1;
      e_a2_d   = hz.D_ReadA2;
      e_wa_d   = hz.D_WriteAddr;
      e_tnew_d = hz.D_Tnew;
    end

    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a1_q   <= '0;
      e_a2_q   <= '0;
      e_wa_q   <= '0;
      e_tnew_q <= '0;
      m_a2_q   <= '0;
      m_wa_q   <= '0;
      m_tnew_q <= '0;
      w_wa_q   <= '0;
      cnt_q    <= '0;
    end else begin
      e_a1_q   <= e_a1_d;
      e_a2_q   <= e_a2_d;
      e_wa_q   <= e_wa_d;
      e_tnew_q <= e_tnew_d;
      m_a2_q   <= e_a2_q;
      m_wa_q   <= e_wa_q;
      m_tnew_q <= m_tnew_d;
      w_wa_q   <= m_wa_q;
      cnt_q    <= cnt_d;
    end
  end

  assign StallCount = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: an instruction-list pipeline model checked every
// cycle, plus literal expectations for the classic load-use/branch/jr/store cases.
module tb_hazard_ctrl;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] StallCount;

  hazard_ctrl_if hif();

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .hz         (hif),
    .StallCount (StallCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-flight instructions by stage (0=E, 1=M, 2=W); remaining Tnew
  // is the decode-time Tnew minus stages advanced past E.
  typedef struct {
    int a1;
    int a2;
    int wa;
    int tnew;
  } ins_t;

  ins_t st[3];
  int   mcount;

  function automatic int rem(input int s);
    return (st[s].tnew - s > 0) ? st[s].tnew - s : 0;
  endfunction

  function automatic bit m_op_stall(input int tuse, input int a);
    if (tuse == 3 || a == 0) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (st[s].wa == a && rem(s) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return m_op_stall(int'(hif.D_Tuse1), int'(hif.D_ReadA1)) ||
           m_op_stall(int'(hif.D_Tuse2), int'(hif.D_ReadA2));
  endfunction

  function automatic int m_dsel(input int a);
    if (a == 0) return 0;
    for (int s = 0; s < 2; s++)
      if (st[s].wa == a) return (rem(s) == 0) ? s + 1 : 0;
    return 0;
  endfunction

  function automatic int m_esel(input int a);
    if (a == 0) return 0;
    if (st[1].wa == a && rem(1) == 0) return 1;
    if (st[2].wa == a) return 2;
    return 0;
  endfunction

  function automatic int m_msel2();
    return (st[1].a2 != 0 && st[2].wa == st[1].a2) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    bit s;
    if (reset) begin
      for (int i = 0; i < 3; i++) st[i] = '{0, 0, 0, 0};
      mcount  = 0;
      started = 1'b1;
    end else if (started) begin
      s = m_stall();
      st[2] = st[1];
      st[1] = st[0];
      if (s) st[0] = '{0, 0, 0, 0};
      else   st[0] = '{int'(hif.D_ReadA1), int'(hif.D_ReadA2),
                       int'(hif.D_WriteAddr), int'(hif.D_Tnew)};
      if (s && mcount < (1 << CW) - 1) mcount++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("stall",      hif.Stall,          m_stall());
      chk("tgrf_sel1",  hif.Trans_grf_Sel1, m_dsel(int'(hif.D_ReadA1)));
      chk("tgrf_sel2",  hif.Trans_grf_Sel2, m_dsel(int'(hif.D_ReadA2)));
      chk("e_sel1",     hif.E_Sel1,         m_esel(st[0].a1));
      chk("e_sel2",     hif.E_Sel2,         m_esel(st[0].a2));
      chk("m_sel2",     hif.M_Sel2,         m_msel2());
      chk("stallcount", StallCount,         mcount);
    end
  end

  task automatic drv(input int t1, input int t2, input int tn,
                     input int a1, input int a2, input int wa);
    hif.D_Tuse1     = 2'(t1);
    hif.D_Tuse2     = 2'(t2);
    hif.D_Tnew      = 2'(tn);
    hif.D_ReadA1    = 5'(a1);
    hif.D_ReadA2    = 5'(a2);
    hif.D_WriteAddr = 5'(wa);
  endtask

  task automatic nop();
    drv(3, 3, 0, 0, 0, 0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    nop();
    adv();
    adv();
    reset = 1'b0;
    settle();
    chk("rst_stall", hif.Stall, 0);
    chk("rst_tsel1", hif.Trans_grf_Sel1, 0);
    chk("rst_esel1", hif.E_Sel1, 0);
    chk("rst_msel2", hif.M_Sel2, 0);
    chk("rst_count", StallCount, 0);

    // lw $1 ; add uses $1 at Tuse 1
    adv(); drv(3, 3, 2, 0, 0, 1);
    adv(); drv(1, 3, 1, 1, 0, 2);
    settle(); chk("lw_add_stall", hif.Stall, 1);
    adv(); settle();
    chk("lw_add_go", hif.Stall, 0);
    chk("lw_add_tsel1", hif.Trans_grf_Sel1, 0);
    adv(); nop(); settle();
    chk("lw_add_esel1", hif.E_Sel1, 2);
    chk("lw_add_count", StallCount, 1);

    // add $3 ; beq uses $3 at Tuse 0
    adv(); drv(3, 3, 1, 0, 0, 3);
    adv(); drv(0, 3, 0, 3, 0, 0);
    settle(); chk("beq_stall", hif.Stall, 1);
    adv(); settle();
    chk("beq_go", hif.Stall, 0);
    chk("beq_tsel1", hif.Trans_grf_Sel1, 2);

    // jal ; jr $31
    adv(); drv(3, 3, 0, 0, 0, 31);
    adv(); drv(0, 3, 0, 31, 0, 0);
    settle();
    chk("jr_stall", hif.Stall, 0);
    chk("jr_tsel1", hif.Trans_grf_Sel1, 1);

    // writes to $0 never hazard
    adv(); drv(3, 3, 2, 0, 0, 0);
    adv(); drv(0, 0, 0, 0, 0, 0);
    settle();
    chk("r0_stall", hif.Stall, 0);
    chk("r0_tsel1", hif.Trans_grf_Sel1, 0);
    chk("r0_tsel2", hif.Trans_grf_Sel2, 0);

    // lw $5 ; sw with rt=$5 at Tuse 2
    adv(); drv(3, 3, 2, 0, 0, 5);
    adv(); drv(1, 2, 0, 0, 5, 0);
    settle(); chk("sw_stall", hif.Stall, 0);
    adv(); nop(); settle();
    adv(); settle();
    chk("sw_msel2", hif.M_Sel2, 1);

    // rs hazards against M, rt against E in the same cycle
    adv(); drv(3, 3, 2, 0, 0, 6);
    adv(); drv(3, 3, 1, 0, 0, 7);
    adv(); drv(0, 0, 0, 6, 7, 0);
    settle(); chk("dual_stall", hif.Stall, 1);
    adv(); settle();
    chk("dual_go", hif.Stall, 0);
    chk("dual_tsel1", hif.Trans_grf_Sel1, 0);
    chk("dual_tsel2", hif.Trans_grf_Sel2, 2);

    // load-use at Tuse 0 stalls twice; repeat until the counter saturates
    for (int i = 0; i < 4; i++) begin
      adv(); drv(3, 3, 2, 0, 0, 9);
      adv(); drv(0, 3, 0, 9, 0, 0);
      settle(); chk("lu0_stall_a", hif.Stall, 1);
      adv(); settle(); chk("lu0_stall_b", hif.Stall, 1);
      adv(); settle(); chk("lu0_go", hif.Stall, 0);
    end
    chk("count_sat", StallCount, 7);

    // back-to-back load-use, reset during the second stall of the second pair
    adv(); drv(3, 3, 2, 0, 0, 1);
    adv(); drv(0, 3, 0, 1, 0, 0);
    adv(); adv();
    adv(); drv(3, 3, 2, 0, 0, 2);
    adv(); drv(0, 3, 0, 2, 0, 0);
    settle(); chk("rst2_stall_a", hif.Stall, 1);
    adv(); settle(); chk("rst2_stall_b", hif.Stall, 1);
    reset = 1'b1;
    adv();
    reset = 1'b0;
    settle();
    chk("rst2_stall", hif.Stall, 0);
    chk("rst2_count", StallCount, 0);
    chk("rst2_tsel1", hif.Trans_grf_Sel1, 0);
    chk("rst2_esel1", hif.E_Sel1, 0);
    chk("rst2_msel2", hif.M_Sel2, 0);
    adv(); nop(); settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
